// File: rtl/uart_key_input_if.sv
// Serial line in, decoded key pulses and framing-error pulse out.
// The master side is the receiver; the slave side is the game FSM or bench.
interface uart_key_if;
  logic rx_in;
  logic up;
  logic down;
  logic left;
  logic right;
  logic enter;
  logic space;
  logic frame_err;

  modport master (
    input  rx_in,
    output up, down, left, right, enter, space, frame_err
  );

  modport slave (
    output rx_in,
    input  up, down, left, right, enter, space, frame_err
  );
endinterface

// File: rtl/uart_key_input.sv
// 8N1 UART receiver plus key decoder for the Tic-Tac-Toe controller.
// Handles CR/LF collapsing, ANSI arrow escapes with timeout and optional WASD keys.
module uart_key_input #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned ESC_TIMEOUT = 1_000_000,
  parameter bit          WASD_EN     = 1'b1
) (
  input logic        clk,
  input logic        reset,
  uart_key_if.master key_if
);
  localparam int unsigned DivRaw = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned Div    = (DivRaw < 1) ? 1 : DivRaw;
  localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned OsW    = $clog2(OVERSAMPLE);
  localparam int unsigned ToW    = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT) : 1;

  localparam int unsigned KUp = 0, KDown = 1, KLeft = 2, KRight = 3, KEnter = 4, KSpace = 5;

  typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;
  typedef enum logic [1:0] {DIdle, DEsc, DCsi} dec_state_e;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            tick;
  logic            sync1_q, rxs;
  rx_state_e       rx_state_q, rx_state_d;
  logic [OsW-1:0]  os_cnt_q, os_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      rx_byte, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;
  dec_state_e      dec_q, dec_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            cr_q, cr_d;
  logic [5:0]      key_q, key_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q    <= '0;
      sync1_q      <= 1'b1;
      rxs          <= 1'b1;
      rx_state_q   <= RIdle;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      rx_byte      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      dec_q        <= DIdle;
      to_cnt_q     <= '0;
      cr_q         <= 1'b0;
      key_q        <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      sync1_q      <= key_if.rx_in;
      rxs          <= sync1_q;
      rx_state_q   <= rx_state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_byte      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      dec_q        <= dec_d;
      to_cnt_q     <= to_cnt_d;
      cr_q         <= cr_d;
      key_q        <= key_d;
    end
  end

  always_comb begin
    tick      = (div_cnt_q == DivW'(Div - 1));
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  // Receiver: start-bit centre after half a bit, then one sample per bit.
  always_comb begin
    rx_state_d   = rx_state_q;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = rx_byte;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (rx_state_q)
      RIdle: begin
        if (!rxs) begin
          os_cnt_d   = '0;
          rx_state_d = RStart;
        end
      end
      RStart: begin
        if (tick) begin
          if (os_cnt_q == OsW'(OVERSAMPLE / 2 - 1)) begin
            os_cnt_d   = '0;
            bit_cnt_d  = '0;
            rx_state_d = rxs ? RIdle : RData;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      RData: begin
        if (tick) begin
          if (os_cnt_q == OsW'(OVERSAMPLE - 1)) begin
            os_cnt_d = '0;
            shift_d  = {rxs, rx_byte[7:1]};
            if (bit_cnt_q == 3'd7) rx_state_d = RStop;
            else                   bit_cnt_d  = bit_cnt_q + 1'b1;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      RStop: begin
        if (tick) begin
          if (os_cnt_q == OsW'(OVERSAMPLE - 1)) begin
            os_cnt_d     = '0;
            rx_state_d   = RIdle;
            byte_valid_d = rxs;
            frame_err_d  = !rxs;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      default: rx_state_d = RIdle;
    endcase
  end

  // Decoder: a byte arriving in the timeout cycle is still handled in the escape state.
  always_comb begin
    dec_d    = dec_q;
    to_cnt_d = to_cnt_q;
    cr_d     = cr_q;
    key_d    = '0;
    if (byte_valid_q) begin
      cr_d     = (rx_byte == 8'h0D);
      to_cnt_d = '0;
      unique case (dec_q)
        DIdle: begin
          case (rx_byte)
            8'h0D:        key_d[KEnter]  = 1'b1;
            8'h0A:        key_d[KEnter]  = !cr_q;
            8'h20:        key_d[KSpace]  = 1'b1;
            8'h77, 8'h57: key_d[KUp]     = WASD_EN;
            8'h73, 8'h53: key_d[KDown]   = WASD_EN;
            8'h61, 8'h41: key_d[KLeft]   = WASD_EN;
            8'h64, 8'h44: key_d[KRight]  = WASD_EN;
            8'h1B:        dec_d          = DEsc;
            default:      ;
          endcase
        end
        DEsc: dec_d = (rx_byte == 8'h5B) ? DCsi : DIdle;
        DCsi: begin
          dec_d = DIdle;
          case (rx_byte)
            8'h41:   key_d[KUp]    = 1'b1;
            8'h42:   key_d[KDown]  = 1'b1;
            8'h43:   key_d[KRight] = 1'b1;
            8'h44:   key_d[KLeft]  = 1'b1;
            default: ;
          endcase
        end
        default: dec_d = DIdle;
      endcase
    end else if (dec_q != DIdle) begin
      if (to_cnt_q == ToW'(ESC_TIMEOUT - 1)) begin
        dec_d    = DIdle;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  assign key_if.up        = key_q[KUp];
  assign key_if.down      = key_q[KDown];
  assign key_if.left      = key_q[KLeft];
  assign key_if.right     = key_q[KRight];
  assign key_if.enter     = key_q[KEnter];
  assign key_if.space     = key_q[KSpace];
  assign key_if.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_key_input.sv
// Directed bench: two receivers (WASD on/off) share one serial line; pulse counts are checked.
module tb_uart_key_input;
  localparam int unsigned BitCyc = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;

  uart_key_if bus_w ();
  uart_key_if bus_n ();
  assign bus_w.rx_in = rx;
  assign bus_n.rx_in = rx;

  uart_key_input #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .ESC_TIMEOUT(200), .WASD_EN(1'b1)
  ) dut_w (.clk(clk), .reset(reset), .key_if(bus_w));

  uart_key_input #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .ESC_TIMEOUT(200), .WASD_EN(1'b0)
  ) dut_n (.clk(clk), .reset(reset), .key_if(bus_n));

  always #5 clk = ~clk;

  // Order: up, down, left, right, enter, space, frame_err.
  int cnt_w [7];
  int cnt_n [7];
  int base_w [7];
  int base_n [7];
  int wide_err  = 0;
  int multi_err = 0;
  int checks    = 0;
  int errors    = 0;
  logic [6:0] prev_w = '0, prev_n = '0;

  wire [6:0] out_w = {bus_w.frame_err, bus_w.space, bus_w.enter, bus_w.right, bus_w.left,
                      bus_w.down, bus_w.up};
  wire [6:0] out_n = {bus_n.frame_err, bus_n.space, bus_n.enter, bus_n.right, bus_n.left,
                      bus_n.down, bus_n.up};

  initial for (int i = 0; i < 7; i++) begin cnt_w[i] = 0; cnt_n[i] = 0; end

  always @(negedge clk) begin
    for (int i = 0; i < 7; i++) begin
      cnt_w[i] = cnt_w[i] + int'(out_w[i]);
      cnt_n[i] = cnt_n[i] + int'(out_n[i]);
    end
    if ((out_w & prev_w) != '0 || (out_n & prev_n) != '0) wide_err = wide_err + 1;
    if ($countones(out_w[5:0]) > 1 || $countones(out_n[5:0]) > 1) multi_err = multi_err + 1;
    prev_w = out_w;
    prev_n = out_n;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 7; i++) begin base_w[i] = cnt_w[i]; base_n[i] = cnt_n[i]; end
  endtask

  function automatic int dw(input int i);
    return cnt_w[i] - base_w[i];
  endfunction

  function automatic int dn(input int i);
    return cnt_n[i] - base_n[i];
  endfunction

  function automatic int keys_w();
    int s = 0;
    for (int i = 0; i < 6; i++) s += dw(i);
    return s;
  endfunction

  function automatic int keys_n();
    int s = 0;
    for (int i = 0; i < 6; i++) s += dn(i);
    return s;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BitCyc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BitCyc) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BitCyc) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check_eq("reset_out_w", int'(out_w), 0);
    check_eq("reset_out_n", int'(out_n), 0);
    reset = 1'b0;
    idle(20);
    check_eq("idle_out_w", int'(out_w), 0);

    // 'w' then space
    snap();
    send_byte(8'h77, 1'b1);
    send_byte(8'h20, 1'b1);
    idle(40);
    check_eq("w_up", dw(0), 1);
    check_eq("w_space", dw(5), 1);
    check_eq("w_keys_total", keys_w(), 2);
    check_eq("n_space_only", keys_n(), 1);
    check_eq("n_space", dn(5), 1);

    // ESC [ D back to back
    snap();
    send_byte(8'h1B, 1'b1);
    send_byte(8'h5B, 1'b1);
    check_eq("csi_prefix_silent", keys_w(), 0);
    send_byte(8'h44, 1'b1);
    idle(40);
    check_eq("csi_left", dw(2), 1);
    check_eq("csi_total", keys_w(), 1);
    check_eq("csi_left_n", dn(2), 1);
    check_eq("csi_total_n", keys_n(), 1);

    // ESC timeout, then '[' 'A'
    snap();
    send_byte(8'h1B, 1'b1);
    idle(300);
    send_byte(8'h5B, 1'b1);
    send_byte(8'h41, 1'b1);
    idle(40);
    check_eq("esc_to_left", dw(2), 1);
    check_eq("esc_to_total", keys_w(), 1);
    check_eq("esc_to_total_n", keys_n(), 0);

    // CR LF, then lone LF
    snap();
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
    idle(30);
    check_eq("crlf_enter", dw(4), 1);
    send_byte(8'h0A, 1'b1);
    idle(40);
    check_eq("lf_enter", dw(4), 2);
    check_eq("lf_enter_n", dn(4), 2);
    check_eq("lf_total", keys_w(), 2);

    // Framing error then good 'd'
    snap();
    send_byte(8'h64, 1'b0);
    idle(60);
    check_eq("ferr_pulse", dw(6), 1);
    check_eq("ferr_no_key", keys_w(), 0);
    send_byte(8'h64, 1'b1);
    idle(40);
    check_eq("after_ferr_right", dw(3), 1);
    check_eq("after_ferr_ferr", dw(6), 1);
    check_eq("after_ferr_n", keys_n(), 0);

    // Short glitch
    snap();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(200);
    check_eq("glitch_keys", keys_w(), 0);
    check_eq("glitch_ferr", dw(6), 0);

    // Line held low: a frame is ~153 cycles, so 400 cycles give two framing errors
    snap();
    rx = 1'b0;
    repeat (400) @(negedge clk);
    idle(300);
    check_eq("low_ferr", dw(6), 2);
    check_eq("low_keys", keys_w(), 0);

    // Reset in the data bits of 's'
    snap();
    rx = 1'b0;
    repeat (BitCyc) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h73 >> i) & 8'h01;
      repeat (BitCyc) @(negedge clk);
    end
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_out_w", int'(out_w), 0);
    check_eq("rst_mid_out_n", int'(out_n), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(250);
    check_eq("rst_mid_down", dw(1), 0);
    check_eq("rst_mid_keys", keys_w(), 0);

    // Recovery after reset
    snap();
    send_byte(8'h53, 1'b1);
    idle(40);
    check_eq("post_rst_down", dw(1), 1);

    check_eq("pulse_width", wide_err, 0);
    check_eq("one_hot", multi_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
